host_uart_command_enc: RTL and testbench
========================================

Name: host_uart_command_enc

Overview:
Host-side response encoder for the UART command link. On a start strobe it captures the response ID, success/fail status and payload, and builds a fixed 32-byte little-endian response frame on output_data. It sits between the command-handling logic and the UART transmit serializer. It pulses done when the frame is valid, and also pulses error when the response ID is unsupported.

Parameters:
ENCRYPT_ENABLE_RSP_ID, 16'h0001, response ID for encrypt-enable acknowledge (no payload)
READ_YAW_RSP_ID, 16'h0002, response ID for yaw read (4-byte payload on success)
INVALID_COMMAND_RSP_ID, 16'h0004, response ID reporting an invalid host command (no payload)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
input_data  in  264  payload source; only bits [31:0] are used (READ_YAW); bits [263:32] are ignored
start  in  1  request strobe, sampled on the rising edge while IDLE
cmd_select  in  16  response ID to encode
suc_or_fail_status  in  1  1 = success, 0 = failure
output_data  out  256  encoded frame; byte k is output_data[8k+7:8k]
done  out  1  one-cycle pulse when output_data is valid
error  out  1  one-cycle pulse, coincident with done, for an unsupported cmd_select

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE.
  - output_data=0, done=0, error=0, and all capture registers cleared.
- FSM states: IDLE -> BUILD -> DONE -> IDLE.
  - IDLE: on clk rise with start=1, capture cmd_select, suc_or_fail_status and input_data[31:0], then go to BUILD. Otherwise stay in IDLE.
  - BUILD: compose the frame into output_data and go to DONE.
  - DONE: drive done=1 (and error per below) for exactly this cycle, then return to IDLE.
- Latency: done is high in the second cycle after the cycle in which start was sampled. The block is ready for a new start the cycle after done.
- start is ignored in BUILD and DONE (no queueing). A start held high continuously re-triggers each time the FSM returns to IDLE.
- output_data holds the last frame until the next BUILD or a reset.
- Frame layout (all unused bytes are zero):
  - byte0 = ID[7:0]
  - byte1 = ID[15:8]
  - byte2 = status: 8'h01 for success, 8'h00 for failure
  - byte3 = payload length in bytes
  - bytes 4..31 = payload
- Per-ID encoding:
  - ENCRYPT_ENABLE: status from suc_or_fail_status; length 0.
  - READ_YAW, success: length 4; bytes4..7 = input_data[7:0], [15:8], [23:16], [31:24].
  - READ_YAW, failure: length 0; no payload.
  - INVALID_COMMAND: status forced to 8'h00 regardless of suc_or_fail_status; length 0; error stays 0.
  - Any other ID: output_data = 0 and error=1 together with done.
- Inputs are captured only in IDLE. Changes on inputs after capture do not affect the frame in progress.
- Reset during BUILD or DONE aborts immediately: no done pulse, and output_data is cleared.

Decomposition:
- Shared package (host_uart_pkg): the three response ID constants, status byte constants (STATUS_OK=8'h01, STATUS_FAIL=8'h00), header byte offsets, FRAME_BYTES=32, and the FSM state enum.
- Single flat module; no sub-module is needed. An internal byte-pack function builds the header.

Test Plan:
- Reset low for 1 cycle, then release -> output_data=0, done=0, error=0.
- ENCRYPT_ENABLE, status=1, start for 1 cycle -> done pulse 2 cycles later; output_data=256'h00010001; error=0.
- READ_YAW, input_data=32'h04030201, status=1 -> output_data[63:0]=64'h0403020104010002, upper bits 0; done pulses once.
- READ_YAW, same data, status=0 -> output_data=256'h00000002; no payload bytes.
- Assert reset mid-sequence, release, then INVALID_COMMAND with input_data=0 -> output_data=256'h00000004; error=0.
- Unsupported cmd_select=16'h0003 -> done=1 and error=1 in the same cycle; output_data=0. A start pulsed during BUILD is ignored.

Source files
------------

// File: rtl/host_uart_pkg.sv
// Shared constants and types for the host UART response encoder.
// The frame is 32 bytes, little-endian; byte k sits at bits [8k+7:8k].
package host_uart_pkg;

  localparam logic [15:0] ENCRYPT_ENABLE_RSP_ID  = 16'h0001;
  localparam logic [15:0] READ_YAW_RSP_ID        = 16'h0002;
  localparam logic [15:0] INVALID_COMMAND_RSP_ID = 16'h0004;

  localparam logic [7:0] STATUS_OK   = 8'h01;
  localparam logic [7:0] STATUS_FAIL = 8'h00;

  localparam int unsigned BYTE_ID_LO   = 32'd0;
  localparam int unsigned BYTE_ID_HI   = 32'd1;
  localparam int unsigned BYTE_STATUS  = 32'd2;
  localparam int unsigned BYTE_LEN     = 32'd3;
  localparam int unsigned BYTE_PAYLOAD = 32'd4;

  localparam int unsigned FRAME_BYTES = 32'd32;
  localparam int unsigned FRAME_BITS  = FRAME_BYTES * 32'd8;

  localparam logic [7:0] YAW_PAYLOAD_LEN = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/host_uart_command_enc.sv
// Host-side response encoder: captures a response request while idle and
// builds a fixed 32-byte response frame, pulsing done (and error) once.
module host_uart_command_enc
  import host_uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [263:0]          input_data,
  input  logic                  start,
  input  logic [15:0]           cmd_select,
  input  logic                  suc_or_fail_status,
  output logic [FRAME_BITS-1:0] output_data,
  output logic                  done,
  output logic                  error
);

  enc_state_e            state_q, state_d;
  logic [15:0]           id_q, id_d;
  logic                  ok_q, ok_d;
  logic [31:0]           yaw_q, yaw_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  // Only the low word carries payload; the rest of input_data is never used.
  logic data_unused_s;
  assign data_unused_s = ^input_data[263:32];

  function automatic logic [31:0] build_header(input logic [15:0] id,
                                               input logic [7:0]  status,
                                               input logic [7:0]  len);
    logic [31:0] h;
    h = 32'h0000_0000;
    h[BYTE_ID_LO*32'd8  +: 8] = id[7:0];
    h[BYTE_ID_HI*32'd8  +: 8] = id[15:8];
    h[BYTE_STATUS*32'd8 +: 8] = status;
    h[BYTE_LEN*32'd8    +: 8] = len;
    return h;
  endfunction

  function automatic logic is_supported(input logic [15:0] id);
    logic s;
    case (id)
      ENCRYPT_ENABLE_RSP_ID,
      READ_YAW_RSP_ID,
      INVALID_COMMAND_RSP_ID: s = 1'b1;
      default:                s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [15:0] id,
                                                        input logic        ok,
                                                        input logic [31:0] yaw);
    logic [FRAME_BITS-1:0] f;
    f = {FRAME_BITS{1'b0}};
    case (id)
      ENCRYPT_ENABLE_RSP_ID: begin
        f[31:0] = build_header(id, ok ? STATUS_OK : STATUS_FAIL, 8'd0);
      end
      READ_YAW_RSP_ID: begin
        if (ok) begin
          f[31:0] = build_header(id, STATUS_OK, YAW_PAYLOAD_LEN);
          f[BYTE_PAYLOAD*32'd8 +: 32] = yaw;
        end else begin
          f[31:0] = build_header(id, STATUS_FAIL, 8'd0);
        end
      end
      // Invalid-command reports always carry a fail status.
      INVALID_COMMAND_RSP_ID: begin
        f[31:0] = build_header(id, STATUS_FAIL, 8'd0);
      end
      default: begin
        f = {FRAME_BITS{1'b0}};
      end
    endcase
    return f;
  endfunction

  // Next-state, capture and frame-build logic.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ok_d    = ok_q;
    yaw_d   = yaw_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          id_d    = cmd_select;
          ok_d    = suc_or_fail_status;
          yaw_d   = input_data[31:0];
          state_d = ST_BUILD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUILD: begin
        frame_d = build_frame(id_q, ok_q, yaw_q);
        done_d  = 1'b1;
        error_d = ~is_supported(id_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      id_q    <= 16'h0000;
      ok_q    <= 1'b0;
      yaw_q   <= 32'h0000_0000;
      frame_q <= {FRAME_BITS{1'b0}};
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ok_q    <= ok_d;
      yaw_q   <= yaw_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign output_data = frame_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_host_uart_command_enc.sv
// Bench for host_uart_command_enc: directed and randomized response requests
// checked against a byte-level reference model of the response frame.
module tb_host_uart_command_enc;

  logic         clk;
  logic         reset;
  logic [263:0] input_data;
  logic         start;
  logic [15:0]  cmd_select;
  logic         suc_or_fail_status;
  logic [255:0] output_data;
  logic         done;
  logic         error;

  int n_checks;
  int n_pass;

  host_uart_command_enc dut (
    .clk                (clk),
    .reset              (reset),
    .input_data         (input_data),
    .start              (start),
    .cmd_select         (cmd_select),
    .suc_or_fail_status (suc_or_fail_status),
    .output_data        (output_data),
    .done               (done),
    .error              (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame built byte by byte from the response rules.
  function automatic logic [255:0] model_frame(input logic [15:0] id, input logic ok,
                                               input logic [31:0] d);
    byte unsigned b[32];
    logic [255:0] f;
    for (int i = 0; i < 32; i++) b[i] = 8'd0;
    if (id == 16'h0001 || id == 16'h0002 || id == 16'h0004) begin
      b[0] = id[7:0];
      b[1] = id[15:8];
      b[2] = (ok && id != 16'h0004) ? 8'd1 : 8'd0;
      if (id == 16'h0002 && ok) begin
        b[3] = 8'd4;
        for (int k = 0; k < 4; k++) b[4+k] = d[8*k +: 8];
      end
    end
    f = '0;
    for (int i = 0; i < 32; i++) f[8*i +: 8] = b[i];
    return f;
  endfunction

  function automatic logic model_error(input logic [15:0] id);
    return !(id == 16'h0001 || id == 16'h0002 || id == 16'h0004);
  endfunction

  function automatic logic [263:0] rand_input();
    logic [263:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    v[263:256] = 8'($urandom);
    return v;
  endfunction

  // Drives one request; returns just after the edge that samples start.
  task automatic send(input logic [15:0] id, input logic ok, input logic [263:0] d);
    cmd_select         = id;
    suc_or_fail_status = ok;
    input_data         = d;
    start              = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    cmd_select = 16'h0000;
    suc_or_fail_status = 1'b0;
    input_data = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (output_data !== 256'h0 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_state: got data=%h done=%b error=%b want all 0", output_data, done, error);
    else n_pass++;
  endtask

  task automatic test_encrypt();
    send(16'h0001, 1'b1, 264'h0);
    n_checks++;
    if (done !== 1'b0) $display("FAIL enc_early_done: got %b want 0", done); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || output_data !== 256'h00010001)
      $display("FAIL enc_frame: got done=%b error=%b data=%h want 1 0 00010001", done, error, output_data);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || output_data !== 256'h00010001)
      $display("FAIL enc_hold: got done=%b data=%h want 0 and held frame", done, output_data);
    else n_pass++;
  endtask

  task automatic test_read_yaw();
    send(16'h0002, 1'b1, 264'h04030201);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || output_data[63:0] !== 64'h0403020104010002 ||
        output_data[255:64] !== 192'h0)
      $display("FAIL yaw_ok: got done=%b error=%b data=%h want 1 0 0403020104010002", done, error, output_data);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL yaw_single_pulse: got done=%b want 0", done); else n_pass++;
    send(16'h0002, 1'b0, 264'h04030201);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || output_data !== 256'h00000002)
      $display("FAIL yaw_fail: got done=%b data=%h want 1 00000002", done, output_data);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    send(16'h0002, 1'b1, 264'h0A0B0C0D);
    reset = 1'b0;
    #1;
    n_checks++;
    if (output_data !== 256'h0 || done !== 1'b0)
      $display("FAIL abort_clear: got data=%h done=%b want 0 0", output_data, done);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || output_data !== 256'h0)
      $display("FAIL abort_no_done: got done=%b data=%h want 0 0", done, output_data);
    else n_pass++;
    send(16'h0004, 1'b1, 264'h0);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || output_data !== 256'h00000004)
      $display("FAIL invalid_cmd: got done=%b error=%b data=%h want 1 0 00000004", done, error, output_data);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    send(16'h0003, 1'b1, 264'h12345678);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || error !== 1'b1 || output_data !== 256'h0)
      $display("FAIL unsup: got done=%b error=%b data=%h want 1 1 0", done, error, output_data);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || error !== 1'b0)
        $display("FAIL unsup_start_ignored: cycle %0d got done=%b error=%b want 0 0", c, done, error);
      else n_pass++;
    end
  endtask

  task automatic test_capture_isolation();
    logic [263:0] d;
    d = rand_input();
    send(16'h0002, 1'b1, d);
    cmd_select = 16'h0001;
    suc_or_fail_status = 1'b0;
    input_data = ~d;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || output_data !== model_frame(16'h0002, 1'b1, d[31:0]))
      $display("FAIL capture_iso: got done=%b data=%h want %h", done, output_data,
               model_frame(16'h0002, 1'b1, d[31:0]));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [263:0] da, db;
    da = rand_input();
    db = rand_input();
    cmd_select = 16'h0002; suc_or_fail_status = 1'b1; input_data = da;
    start = 1'b1;
    @(posedge clk); #1;
    cmd_select = 16'h0001; suc_or_fail_status = 1'b1; input_data = db;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || output_data !== model_frame(16'h0002, 1'b1, da[31:0]))
      $display("FAIL b2b_first: got done=%b data=%h", done, output_data);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL b2b_gap: got done=%b want 0", done); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || output_data !== model_frame(16'h0001, 1'b1, db[31:0]))
      $display("FAIL b2b_second: got done=%b data=%h", done, output_data);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL b2b_stop: got done=%b want 0", done); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0]  id;
    logic         ok;
    logic [263:0] d;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0: id = 16'h0001;
        1: id = 16'h0002;
        2: id = 16'h0004;
        default: id = 16'($urandom);
      endcase
      ok = 1'($urandom);
      d  = rand_input();
      send(id, ok, d);
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || error !== model_error(id) || output_data !== model_frame(id, ok, d[31:0]))
        $display("FAIL rand_%0d: id=%h ok=%b got done=%b error=%b data=%h want error=%b data=%h",
                 t, id, ok, done, error, output_data, model_error(id), model_frame(id, ok, d[31:0]));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_encrypt();
    test_read_yaw();
    test_reset_abort();
    test_unsupported();
    test_capture_isolation();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
